// File: rtl/thash_f_chain_if.sv
// rtl/thash_f_chain_if.sv - request/response port between the WOTS chain engine and the shared SHA-256 core
interface thash_f_chain_if #(
    parameter int KEY_LEN = 256
);
    logic               hash_start;
    logic [1023:0]      hash_data_in;
    logic               message_length;
    logic               hash_done;
    logic [KEY_LEN-1:0] hash_data_out;

    modport master (
        output hash_start,
        output hash_data_in,
        output message_length,
        input  hash_done,
        input  hash_data_out
    );

    modport slave (
        input  hash_start,
        input  hash_data_in,
        input  message_length,
        output hash_done,
        output hash_data_out
    );
endinterface

// File: rtl/thash_f_chain.sv
// rtl/thash_f_chain.sv - WOTS chain engine applying the XMSS tweakable hash F over a shared SHA-256 port
module thash_f_chain #(
    parameter int KEY_LEN               = 256,
    parameter int W_LOG                 = 4,
    parameter int XMSS_HASH_PADDING_F   = 0,
    parameter int XMSS_HASH_PADDING_PRF = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KEY_LEN-1:0] pub_seed,
    input  logic [KEY_LEN-1:0] input_data,
    input  logic [W_LOG-1:0]   start_idx,
    input  logic [W_LOG-1:0]   steps,
    input  logic [255:0]       hash_addr,
    output logic [KEY_LEN-1:0] data_out,
    output logic [255:0]       hash_addr_updated,
    output logic               busy,
    output logic               done,
    thash_f_chain_if.master    hash_if
);

    localparam int W = 1 << W_LOG;
    localparam logic [KEY_LEN-1:0] PAD_F   = KEY_LEN'(XMSS_HASH_PADDING_F);
    localparam logic [KEY_LEN-1:0] PAD_PRF = KEY_LEN'(XMSS_HASH_PADDING_PRF);

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        PRF_K,
        WAIT_K,
        PRF_M,
        WAIT_M,
        F,
        WAIT_F,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               hash_start_q, hash_start_d;
    logic [1023:0]      hash_data_in_q, hash_data_in_d;
    logic [KEY_LEN-1:0] data_out_q, data_out_d;
    logic [255:0]       hau_q, hau_d;
    logic [KEY_LEN-1:0] seed_q, seed_d;
    logic [KEY_LEN-1:0] acc_q, acc_d;
    logic [KEY_LEN-1:0] key_q, key_d;
    logic [KEY_LEN-1:0] mask_q, mask_d;
    logic [255:0]       adrs_q, adrs_d;
    logic [W_LOG-1:0]   idx_q, idx_d;
    logic [W_LOG-1:0]   cnt_q, cnt_d;

    logic [W_LOG-1:0]   room;
    logic [W_LOG-1:0]   eff;
    logic               hdone;
    logic [KEY_LEN-1:0] hdo;

    assign hdone = hash_if.hash_done;
    assign hdo   = hash_if.hash_data_out;

    // Messages are left-aligned in the 1024-bit block; unused low bits stay zero.
    function automatic logic [1023:0] build_msg(input logic [KEY_LEN-1:0] pad,
                                                input logic [KEY_LEN-1:0] key,
                                                input logic [KEY_LEN-1:0] payload);
        logic [1023:0] m;
        m = '0;
        m[1023 -: 3*KEY_LEN] = {pad, key, payload};
        return m;
    endfunction

    // Clamp so the chain never walks past position W-1.
    always_comb begin
        room = W_LOG'(W - 1) - start_idx;
        eff  = (steps < room) ? steps : room;
    end

    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        hash_start_d   = 1'b0;
        hash_data_in_d = hash_data_in_q;
        data_out_d     = data_out_q;
        hau_d          = hau_q;
        seed_d         = seed_q;
        acc_d          = acc_q;
        key_d          = key_q;
        mask_d         = mask_q;
        adrs_d         = adrs_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d  = pub_seed;
                    acc_d   = input_data;
                    adrs_d  = hash_addr;
                    idx_d   = start_idx;
                    cnt_d   = eff;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cnt_q == '0) begin
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    data_out_d = acc_q;
                    hau_d      = {adrs_q[255:32], 32'd0};
                    state_d    = DONE;
                end else begin
                    adrs_d         = {adrs_q[255:64], {(32-W_LOG){1'b0}}, idx_q, 32'd0};
                    hash_start_d   = 1'b1;
                    hash_data_in_d = build_msg(PAD_PRF, seed_q, KEY_LEN'(adrs_d));
                    state_d        = PRF_K;
                end
            end
            PRF_K: state_d = WAIT_K;
            WAIT_K: begin
                if (hdone) begin
                    key_d          = hdo;
                    adrs_d         = {adrs_q[255:32], 32'd1};
                    hash_start_d   = 1'b1;
                    hash_data_in_d = build_msg(PAD_PRF, seed_q, KEY_LEN'(adrs_d));
                    state_d        = PRF_M;
                end
            end
            PRF_M: state_d = WAIT_M;
            WAIT_M: begin
                if (hdone) begin
                    mask_d         = hdo;
                    hash_start_d   = 1'b1;
                    hash_data_in_d = build_msg(PAD_F, key_q, acc_q ^ mask_d);
                    state_d        = F;
                end
            end
            F: state_d = WAIT_F;
            WAIT_F: begin
                if (hdone) begin
                    acc_d   = hdo;
                    idx_d   = idx_q + W_LOG'(1);
                    cnt_d   = cnt_q - W_LOG'(1);
                    state_d = CHECK;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            hash_start_q   <= 1'b0;
            hash_data_in_q <= '0;
            data_out_q     <= '0;
            hau_q          <= '0;
            seed_q         <= '0;
            acc_q          <= '0;
            key_q          <= '0;
            mask_q         <= '0;
            adrs_q         <= '0;
            idx_q          <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            hash_start_q   <= hash_start_d;
            hash_data_in_q <= hash_data_in_d;
            data_out_q     <= data_out_d;
            hau_q          <= hau_d;
            seed_q         <= seed_d;
            acc_q          <= acc_d;
            key_q          <= key_d;
            mask_q         <= mask_d;
            adrs_q         <= adrs_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
        end
    end

    assign busy                   = busy_q;
    assign done                   = done_q;
    assign data_out               = data_out_q;
    assign hash_addr_updated      = hau_q;
    assign hash_if.hash_start     = hash_start_q;
    assign hash_if.hash_data_in   = hash_data_in_q;
    assign hash_if.message_length = 1'b1;

endmodule
